// File: rtl/seg7_scan_display.sv
// Multiplexed hex 7-segment driver: double-buffered display data, PWM brightness, guard gap.
// Latency: an/seg/dp are registered, one cycle behind the scan counters; frame_done/pending come straight from registers.
// Backpressure: none; a load is always accepted and takes effect at the next frame boundary.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   value              hex nibbles, [3:0] = digit 0 (rightmost, an[0])
//   dp_in, blank       per-digit decimal point enable / force dark
//   lzb, brightness    leading-zero blanking enable, duty code
//   load               one-cycle strobe that stages all of the above
//   an, seg, dp        board pins (polarity chosen by ACTIVE_LOW), seg[0]=a .. seg[6]=g
//   pending            staged data waiting for the frame boundary
//   frame_done         high during the last cycle of every frame
module seg7_scan_display #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int DIGITS     = 4,
    parameter int BR_W       = 4,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lzb,
    input  logic [BR_W-1:0]       brightness,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int   DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int   TW  = $clog2(DIV + 1);
    localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic OFF = (ACTIVE_LOW != 0);

    // A slot with no cycles outside the guard gap can never light anything.
    if (DIV <= GUARD) begin : g_div_check
        $error("seg7_scan_display: DIV must exceed GUARD");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
        endcase
    endfunction

    logic [TW-1:0]       tick_q, tick_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                boundary;

    logic [4*DIGITS-1:0] st_value_q, sh_value_q;
    logic [DIGITS-1:0]   st_dp_q, sh_dp_q, st_blank_q, sh_blank_q;
    logic                st_lzb_q, sh_lzb_q;
    logic [BR_W-1:0]     st_br_q, sh_br_q;
    logic                pending_q, pending_d;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    // ---------------- scan counters ----------------
    assign boundary = (tick_q == TW'(DIV - 1)) && (idx_q == IW'(DIGITS - 1));

    always_comb begin
        tick_d = tick_q + TW'(1);
        idx_d  = idx_q;
        if (tick_q == TW'(DIV - 1)) begin
            tick_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // ---------------- staging / shadow ----------------
    // A load on the boundary itself bypasses staging so the very next frame
    // shows it and pending never rises.
    always_comb begin
        pending_d = pending_q;
        if (boundary)  pending_d = 1'b0;
        else if (load) pending_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            st_value_q <= '0;
            st_dp_q    <= '0;
            st_blank_q <= '0;
            st_lzb_q   <= 1'b0;
            st_br_q    <= '0;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_lzb_q   <= 1'b0;
            sh_br_q    <= '1;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            if (load) begin
                st_value_q <= value;
                st_dp_q    <= dp_in;
                st_blank_q <= blank;
                st_lzb_q   <= lzb;
                st_br_q    <= brightness;
            end
            if (boundary && load) begin
                sh_value_q <= value;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank;
                sh_lzb_q   <= lzb;
                sh_br_q    <= brightness;
            end else if (boundary && pending_q) begin
                sh_value_q <= st_value_q;
                sh_dp_q    <= st_dp_q;
                sh_blank_q <= st_blank_q;
                sh_lzb_q   <= st_lzb_q;
                sh_br_q    <= st_br_q;
            end
        end
    end

    // ---------------- digit selection ----------------
    logic [DIGITS:0]   hi_zero;   // hi_zero[k]: nibble k and all above it are zero
    logic [3:0]        nib;
    logic              supp, lit;
    logic [31:0]       win_w;
    logic [DIGITS-1:0] an_ah;
    logic [6:0]        seg_ah;
    logic              dp_ah;

    always_comb begin
        hi_zero         = '0;
        hi_zero[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero[k] = hi_zero[k+1] && (sh_value_q[4*k +: 4] == 4'h0);
        end
        nib   = sh_value_q[4*idx_q +: 4];
        supp  = sh_lzb_q && (idx_q != '0) && hi_zero[idx_q];
        // Lit window end scales the slot length by (code+1)/2^BR_W.
        win_w = ((32'(sh_br_q) + 32'd1) * 32'(DIV)) >> BR_W;
        lit   = (32'(tick_q) >= 32'(GUARD)) && (32'(tick_q) < win_w) && !sh_blank_q[idx_q];

        // Segments follow idx for the whole slot, so they only switch at
        // tick 0, which lies inside the guard gap where all anodes are off.
        an_ah  = lit ? (DIGITS'(1) << idx_q) : '0;
        seg_ah = (sh_blank_q[idx_q] || supp) ? 7'h00 : hex7(nib);
        dp_ah  = sh_dp_q[idx_q] && !sh_blank_q[idx_q];

        an_d  = an_ah ^ {DIGITS{OFF}};
        seg_d = seg_ah ^ {7{OFF}};
        dp_d  = dp_ah ^ OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= {DIGITS{OFF}};
            seg_q <= {7{OFF}};
            dp_q  <= OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in, blank, brightness;
    logic        lzb, load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, pending, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_display #(
        .CLK_HZ(6400), .SCAN_HZ(100), .DIGITS(4), .BR_W(4), .GUARD(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .lzb(lzb),
        .brightness(brightness), .load(load), .an(an), .seg(seg), .dp(dp),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // One frame's worth of stimulus and the expected pin levels (active-low).
    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic [3:0]      blank;
        logic            lzb;
        logic [3:0]      br;
        int              w;     // first tick past the lit window
        logic [3:0]      on;    // digits whose anode is driven in the window
        logic [3:0][6:0] seg;   // expected seg pins per digit
        logic [3:0]      dp;    // expected dp pin per digit
    } rec_t;

    rec_t tbl [8];
    rec_t r2222;

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, j, act, exp);
        end
    endtask

    task automatic wait_boundary();
        int k = 0;
        while (frame_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("boundary_reached", k, frame_done, 1);
    endtask

    // Entered at the negedge where the counters sit at tick 0 / idx 0.
    // Sample j shows the outputs registered from counter state j.
    task automatic check_frame(input rec_t r);
        logic [3:0] one_hot, exp_an;
        logic       act_on;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            one_hot = 4'b0001 << (j / 16);
            act_on  = r.on[j/16] && (j % 16) >= 2 && (j % 16) < r.w;
            exp_an  = act_on ? ~one_hot : 4'hF;
            chk("an", j, an, exp_an);
            if (act_on) begin
                chk("seg", j, seg, r.seg[j/16]);
                chk("dp", j, dp, r.dp[j/16]);
            end
            // Counters are one step ahead of the registered pins here.
            chk("frame_done", j, frame_done, j == 62);
            chk("pending_idle", j, pending, 0);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic z, input logic [3:0] br);
        value = v; dp_in = d; blank = b; lzb = z; brightness = br;
    endtask

    initial begin
        int n, dig;
        //            value     dp    blank lzb  br    w   on     seg d3..d0                         dp pins
        tbl[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 16, 4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        tbl[1] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h7,  8, 4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        tbl[2] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h1,  2, 4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        tbl[3] = '{16'h0005, 4'h4, 4'h0, 1'b1, 4'hF, 16, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1011};
        tbl[4] = '{16'h8888, 4'hF, 4'h5, 1'b0, 4'hF, 16, 4'hA, {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0};
        tbl[5] = '{16'h0300, 4'h0, 4'h0, 1'b1, 4'hF, 16, 4'hF, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'hF};
        tbl[6] = '{16'hBCDE, 4'h0, 4'h0, 1'b0, 4'hF, 16, 4'hF, {7'h03, 7'h46, 7'h21, 7'h06}, 4'hF};
        tbl[7] = '{16'h9764, 4'h0, 4'h0, 1'b0, 4'hF, 16, 4'hF, {7'h10, 7'h78, 7'h02, 7'h19}, 4'hF};
        r2222  = '{16'h2222, 4'h0, 4'h0, 1'b0, 4'hF, 16, 4'hF, {4{7'h24}}, 4'hF};

        rst = 1'b1; load = 1'b0;
        drive(16'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        repeat (3) @(negedge clk);
        chk("rst_an", 0, an, 4'hF);
        chk("rst_seg", 0, seg, 7'h7F);
        chk("rst_dp", 0, dp, 1);
        chk("rst_pending", 0, pending, 0);
        chk("rst_frame_done", 0, frame_done, 0);
        rst = 1'b0;

        // Table: each record is loaded on the frame_done cycle itself.
        for (int i = 0; i < 8; i++) begin
            wait_boundary();
            drive(tbl[i].value, tbl[i].dp_in, tbl[i].blank, tbl[i].lzb, tbl[i].br);
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            chk("boundary_load_pending", i, pending, 0);
            check_frame(tbl[i]);
        end

        // Two loads inside one frame: old data holds until the boundary, last load wins.
        repeat (5) @(negedge clk);
        drive(16'h1111, 4'h0, 4'h0, 1'b0, 4'hF);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_after_load1", 0, pending, 1);
        repeat (10) @(negedge clk);
        drive(16'h2222, 4'h0, 4'h0, 1'b0, 4'hF);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_after_load2", 0, pending, 1);
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            chk("pending_held", n, pending, 1);
            if (an != 4'hF) begin
                dig = 0;
                for (int b = 0; b < 4; b++) if (an[b] == 1'b0) dig = b;
                chk("old_seg", n, seg, tbl[7].seg[dig]);
            end
            @(negedge clk);
            n++;
        end
        chk("dbl_boundary_reached", n, frame_done, 1);
        chk("pending_at_boundary", 0, pending, 1);
        @(negedge clk);
        chk("pending_cleared", 0, pending, 0);
        check_frame(r2222);

        // Reset in the middle of a slot with a load pending.
        repeat (20) @(negedge clk);
        drive(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_before_rst", 0, pending, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_an", 0, an, 4'hF);
        chk("midrst_seg", 0, seg, 7'h7F);
        chk("midrst_dp", 0, dp, 1);
        chk("midrst_pending", 0, pending, 0);
        chk("midrst_frame_done", 0, frame_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Counters restart at 0: the boundary is the 64th cycle, 63 edges on.
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_frame_done_after_rst", 0, n, 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
